enable_burst_sequencer: RTL and testbench
=========================================

ENABLE_BURST_SEQUENCER -- requirements
Module: enable_burst_sequencer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 32, width of burst_length, pre_delay and pulse_count.
REQ-002 clock  in  1  system clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a burst.
REQ-005 stop  in  1  single-cycle abort request.
REQ-006 trigger  in  1  external trigger level, synchronous to clock.
REQ-007 arm_mode  in  1  1: wait for trigger rising edge after start; 0: proceed immediately.
REQ-008 pre_delay  in  COUNTER_WIDTH  cycles between start/trigger and enabling the generator.
REQ-009 burst_length  in  COUNTER_WIDTH  number of enable pulses per burst; 0 = continuous until stop.
REQ-010 enable_pulse_in  in  1  enable pulse from the enable generator output being sequenced.
REQ-011 gen_enable_out  out  1  drives the enable generator gen_enable_in.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  single-cycle pulse on normal burst completion.
REQ-014 aborted  out  1  single-cycle pulse when stop terminates activity.
REQ-015 pulse_count  out  COUNTER_WIDTH  enable pulses counted in current/last burst.
REQ-016 state  out  2  current state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, ARMED=1, DELAY=2, RUN=3.
REQ-018 In IDLE, start SHALL latch pre_delay and burst_length, clear pulse_count, and move next cycle to ARMED if arm_mode=1, else to DELAY if latched pre_delay>0, else to RUN.
REQ-019 start while busy SHALL be ignored; config inputs SHALL only be sampled at accepted start.
REQ-020 Trigger rising edge SHALL be detected as trigger=1 with previous-cycle trigger=0; previous value resets to 0; a trigger already high on entering ARMED SHALL NOT count as an edge.
REQ-021 In ARMED, a detected edge SHALL move to DELAY (pre_delay>0) or RUN (pre_delay=0) on the next cycle.
REQ-022 DELAY SHALL last exactly latched pre_delay cycles, then enter RUN.
REQ-023 gen_enable_out SHALL be registered and high exactly while state=RUN.
REQ-024 In RUN, each cycle with enable_pulse_in=1 SHALL increment pulse_count by 1, saturating at all-ones.
REQ-025 When the increment makes pulse_count equal a non-zero latched burst_length, next cycle SHALL be IDLE with done=1 for that one cycle.
REQ-026 With latched burst_length=0, RUN SHALL persist until stop; pulse_count saturates without wrapping.
REQ-027 stop in ARMED, DELAY or RUN SHALL force IDLE next cycle with aborted=1 for one cycle and no done; stop in IDLE SHALL have no effect.
REQ-028 stop SHALL win over a simultaneous final pulse (aborted, not done) and over a simultaneous start in IDLE (start ignored).
REQ-029 enable_pulse_in outside RUN SHALL be ignored; pulse_count SHALL hold its value in IDLE until the next accepted start.
REQ-030 Latency: start at cycle N with arm_mode=0, pre_delay=D SHALL give gen_enable_out high from cycle N+1+D.

Reset
REQ-031 On reset SHALL: state=IDLE, gen_enable_out=0, busy=0, done=0, aborted=0, pulse_count=0, latched config=0, delay counter=0, trigger history=0.
REQ-032 Reset asserted mid-burst SHALL deassert gen_enable_out asynchronously without producing done or aborted.

Structure
REQ-033 State enum and encodings SHALL live in package enable_sequencer_pkg.
REQ-034 Trigger edge detection SHALL be a sub-module named rising_edge_detector; all else in one module.

Verification
REQ-035 arm_mode=0, pre_delay=0, burst_length=3, start at N, pulses every 4 cycles -> gen_enable_out high N+1, done one cycle after 3rd pulse, pulse_count=3.
REQ-036 arm_mode=1, pre_delay=5, trigger edge at T -> DELAY at T+1, gen_enable_out high from T+6.
REQ-037 burst_length=0, 10 pulses, then stop -> gen_enable_out low next cycle, aborted=1, done=0, pulse_count=10.
REQ-038 burst_length=2, stop coincident with 2nd pulse -> aborted=1, done never asserted.
REQ-039 trigger held high before start with arm_mode=1 -> remains ARMED until trigger falls and rises.
REQ-040 reset asserted during RUN -> all outputs zero immediately; new start after release operates normally.

Source files
------------

// File: rtl/enable_sequencer_pkg.sv
// Shared types for the enable burst sequencer: FSM state encoding.
package enable_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        RUN   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/enable_burst_sequencer_rising_edge_detector.sv
// One-cycle rise detector for a level that is already synchronous to clock.
module rising_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Remember the previous-cycle level so a level already high never reads as an edge.
    always_comb begin
        prev_d = level;
    end

    // History register, cleared to 0 on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/enable_burst_sequencer.sv
// Sequences an external enable generator: optional trigger arming, a pre-delay,
// then a run phase that counts enable pulses until the burst length or a stop.
module enable_burst_sequencer
    import enable_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     trigger,
    input  logic                     arm_mode,
    input  logic [COUNTER_WIDTH-1:0] pre_delay,
    input  logic [COUNTER_WIDTH-1:0] burst_length,
    input  logic                     enable_pulse_in,
    output logic                     gen_enable_out,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [COUNTER_WIDTH-1:0] pulse_count,
    output logic [STATE_W-1:0]       state
);

    localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = {COUNTER_WIDTH{1'b1}};

    seq_state_e               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] pre_delay_q, pre_delay_d;
    logic [COUNTER_WIDTH-1:0] burst_len_q, burst_len_d;
    logic [COUNTER_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [COUNTER_WIDTH-1:0] pulse_count_q, pulse_count_d;
    logic                     gen_enable_q, gen_enable_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     trig_rise;

    rising_edge_detector u_trig_edge (
        .clock (clock),
        .reset (reset),
        .level (trigger),
        .rise  (trig_rise)
    );

    // Next-state, config latching, delay countdown and pulse counting; stop has top priority.
    always_comb begin
        state_d       = state_q;
        pre_delay_d   = pre_delay_q;
        burst_len_d   = burst_len_q;
        delay_cnt_d   = delay_cnt_q;
        pulse_count_d = pulse_count_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    pre_delay_d   = pre_delay;
                    burst_len_d   = burst_length;
                    pulse_count_d = '0;
                    if (arm_mode) begin
                        state_d = ARMED;
                    end else if (pre_delay != '0) begin
                        state_d     = DELAY;
                        delay_cnt_d = pre_delay - ONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (trig_rise) begin
                    if (pre_delay_q != '0) begin
                        state_d     = DELAY;
                        delay_cnt_d = pre_delay_q - ONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DELAY: begin
                if (stop) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (delay_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    delay_cnt_d = delay_cnt_q - ONE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (enable_pulse_in) begin
                    if (pulse_count_q != ALL_ONES) begin
                        pulse_count_d = pulse_count_q + ONE;
                    end
                    if ((burst_len_q != '0) && (pulse_count_d == burst_len_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gen_enable_d = (state_d == RUN);
    end

    // State and datapath registers; reset clears everything including the generator enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pre_delay_q   <= '0;
            burst_len_q   <= '0;
            delay_cnt_q   <= '0;
            pulse_count_q <= '0;
            gen_enable_q  <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_delay_q   <= pre_delay_d;
            burst_len_q   <= burst_len_d;
            delay_cnt_q   <= delay_cnt_d;
            pulse_count_q <= pulse_count_d;
            gen_enable_q  <= gen_enable_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign gen_enable_out = gen_enable_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign pulse_count    = pulse_count_q;
    assign state          = state_q;

endmodule

// File: tb/tb_enable_burst_sequencer.sv
// Directed bench for enable_burst_sequencer with a narrow counter so saturation is reachable.
module tb_enable_burst_sequencer;

    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic          stop;
    logic          trigger;
    logic          arm_mode;
    logic [CW-1:0] pre_delay;
    logic [CW-1:0] burst_length;
    logic          enable_pulse_in;
    logic          gen_enable_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] pulse_count;
    logic [1:0]    state;

    int checks;
    int errors;

    enable_burst_sequencer #(.COUNTER_WIDTH(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .trigger         (trigger),
        .arm_mode        (arm_mode),
        .pre_delay       (pre_delay),
        .burst_length    (burst_length),
        .enable_pulse_in (enable_pulse_in),
        .gen_enable_out  (gen_enable_out),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .pulse_count     (pulse_count),
        .state           (state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a configuration with a one-cycle start pulse.
    task automatic applyStimulus(input logic arm, input logic [CW-1:0] pd, input logic [CW-1:0] bl);
        arm_mode     = arm;
        pre_delay    = pd;
        burst_length = bl;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        trigger = 1'b0;
        arm_mode = 1'b0;
        pre_delay = '0;
        burst_length = '0;
        enable_pulse_in = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_gen", 32'(gen_enable_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_aborted", 32'(aborted), 32'd0);
        checkOutput("rst_count", 32'(pulse_count), 32'd0);
        reset = 1'b0;
        tick();

        // Immediate run, burst of 3 with pulses every 4 cycles
        applyStimulus(1'b0, 4'd0, 4'd3);
        checkOutput("b3_state_run", 32'(state), 32'd3);
        checkOutput("b3_gen_high", 32'(gen_enable_out), 32'd1);
        checkOutput("b3_busy", 32'(busy), 32'd1);
        checkOutput("b3_count0", 32'(pulse_count), 32'd0);
        for (int p = 1; p <= 3; p++) begin
            repeat (3) tick();
            enable_pulse_in = 1'b1;
            tick();
            enable_pulse_in = 1'b0;
            if (p < 3) begin
                checkOutput("b3_count_mid", 32'(pulse_count), 32'(p));
                checkOutput("b3_done_mid", 32'(done), 32'd0);
            end
        end
        checkOutput("b3_done", 32'(done), 32'd1);
        checkOutput("b3_state_idle", 32'(state), 32'd0);
        checkOutput("b3_gen_low", 32'(gen_enable_out), 32'd0);
        checkOutput("b3_count3", 32'(pulse_count), 32'd3);
        tick();
        checkOutput("b3_done_pulse", 32'(done), 32'd0);
        enable_pulse_in = 1'b1;
        tick();
        enable_pulse_in = 1'b0;
        checkOutput("idle_pulse_ignored", 32'(pulse_count), 32'd3);

        // Armed with pre_delay 5, config changed after start, start while busy
        trigger = 1'b0;
        applyStimulus(1'b1, 4'd5, 4'd2);
        pre_delay = 4'd9;
        arm_mode = 1'b0;
        checkOutput("arm_state", 32'(state), 32'd1);
        checkOutput("arm_count_clear", 32'(pulse_count), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("arm_start_ignored", 32'(state), 32'd1);
        trigger = 1'b1;
        tick();
        checkOutput("arm_delay_t1", 32'(state), 32'd2);
        repeat (4) tick();
        checkOutput("arm_delay_t5", 32'(state), 32'd2);
        checkOutput("arm_gen_t5", 32'(gen_enable_out), 32'd0);
        tick();
        checkOutput("arm_run_t6", 32'(state), 32'd3);
        checkOutput("arm_gen_t6", 32'(gen_enable_out), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("arm_stop_aborted", 32'(aborted), 32'd1);
        checkOutput("arm_stop_done", 32'(done), 32'd0);
        checkOutput("arm_stop_idle", 32'(state), 32'd0);
        tick();
        checkOutput("arm_aborted_pulse", 32'(aborted), 32'd0);

        // Trigger already high before start must not count
        trigger = 1'b1;
        tick();
        applyStimulus(1'b1, 4'd0, 4'd1);
        repeat (3) tick();
        checkOutput("hi_trig_still_armed", 32'(state), 32'd1);
        trigger = 1'b0;
        tick();
        checkOutput("hi_trig_fall_armed", 32'(state), 32'd1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        checkOutput("hi_trig_run", 32'(state), 32'd3);
        checkOutput("hi_trig_gen", 32'(gen_enable_out), 32'd1);
        enable_pulse_in = 1'b1;
        tick();
        enable_pulse_in = 1'b0;
        checkOutput("bl1_done", 32'(done), 32'd1);
        checkOutput("bl1_count", 32'(pulse_count), 32'd1);

        // Continuous burst: 10 pulses then stop
        applyStimulus(1'b0, 4'd0, 4'd0);
        enable_pulse_in = 1'b1;
        repeat (10) tick();
        enable_pulse_in = 1'b0;
        checkOutput("cont_count10", 32'(pulse_count), 32'd10);
        checkOutput("cont_still_run", 32'(state), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("cont_gen_low", 32'(gen_enable_out), 32'd0);
        checkOutput("cont_aborted", 32'(aborted), 32'd1);
        checkOutput("cont_done", 32'(done), 32'd0);
        checkOutput("cont_count_hold", 32'(pulse_count), 32'd10);

        // Continuous burst saturates at all-ones
        applyStimulus(1'b0, 4'd0, 4'd0);
        enable_pulse_in = 1'b1;
        repeat (20) tick();
        enable_pulse_in = 1'b0;
        checkOutput("sat_count", 32'(pulse_count), 32'd15);
        checkOutput("sat_run", 32'(state), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Stop coincident with final pulse of burst_length 2
        applyStimulus(1'b0, 4'd0, 4'd2);
        enable_pulse_in = 1'b1;
        tick();
        checkOutput("race_count1", 32'(pulse_count), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        enable_pulse_in = 1'b0;
        checkOutput("race_aborted", 32'(aborted), 32'd1);
        checkOutput("race_done", 32'(done), 32'd0);
        checkOutput("race_idle", 32'(state), 32'd0);
        tick();
        checkOutput("race_done_after", 32'(done), 32'd0);

        // Stop with start in IDLE: start ignored, no abort
        stop = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd1);
        stop = 1'b0;
        checkOutput("idle_stop_state", 32'(state), 32'd0);
        checkOutput("idle_stop_aborted", 32'(aborted), 32'd0);

        // Pre-delay 3 without arming: enable from N+4
        applyStimulus(1'b0, 4'd3, 4'd0);
        checkOutput("pd3_delay_n1", 32'(state), 32'd2);
        enable_pulse_in = 1'b1;
        tick();
        tick();
        enable_pulse_in = 1'b0;
        checkOutput("pd3_gen_n3", 32'(gen_enable_out), 32'd0);
        checkOutput("pd3_delay_pulse_ignored", 32'(pulse_count), 32'd0);
        tick();
        checkOutput("pd3_gen_n4", 32'(gen_enable_out), 32'd1);

        // Asynchronous reset during RUN, then a fresh burst
        enable_pulse_in = 1'b1;
        tick();
        tick();
        enable_pulse_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_gen", 32'(gen_enable_out), 32'd0);
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_count", 32'(pulse_count), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_aborted", 32'(aborted), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("arst_post_done", 32'(done), 32'd0);
        checkOutput("arst_post_aborted", 32'(aborted), 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd1);
        checkOutput("arst_new_run", 32'(state), 32'd3);
        enable_pulse_in = 1'b1;
        tick();
        enable_pulse_in = 1'b0;
        checkOutput("arst_new_done", 32'(done), 32'd1);
        checkOutput("arst_new_count", 32'(pulse_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
